// File: rtl/cartoon_pkg.sv
// Shared types and helpers for the HSV cartoon effect stage and related HSV effects.
// Channel layout of a packed pixel: H in the top slot, then S, then V.
package cartoon_pkg;

  localparam int DEF_CH_W = 8;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_BLACK  = 2'd1,
    MODE_DARKEN = 2'd2,
    MODE_EDGE   = 2'd3
  } mode_e;

  function automatic int h_lsb(input int ch_w);
    return 2 * ch_w;
  endfunction

  function automatic int s_lsb(input int ch_w);
    return ch_w;
  endfunction

  function automatic int v_lsb(input int ch_w);
    return 0 * ch_w;
  endfunction

  // Adds two unsigned values and clamps the sum to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return lim[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/cartoon_fx_if.sv
// Pixel stream bundle for the cartoon stage: qualified input pixel with syncs,
// and the matching delayed output stream.
interface cartoon_fx_if #(
  parameter int CH_W = 8
);
  localparam int PIX_W = 3 * CH_W;

  logic             in_valid;
  logic             in_vsync;
  logic             in_hsync;
  logic [CH_W-1:0]  edge_in;
  logic [PIX_W-1:0] blur_in;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] pass_in;

  logic             out_valid;
  logic             out_vsync;
  logic             out_hsync;
  logic [PIX_W-1:0] pixel_out;
  logic [PIX_W-1:0] pass_out;

  modport master (
    output in_valid, in_vsync, in_hsync, edge_in, blur_in, pixel_in, pass_in,
    input  out_valid, out_vsync, out_hsync, pixel_out, pass_out
  );

  modport slave (
    input  in_valid, in_vsync, in_hsync, edge_in, blur_in, pixel_in, pass_in,
    output out_valid, out_vsync, out_hsync, pixel_out, pass_out
  );
endinterface

// File: rtl/cartoon_sat_boost.sv
// Saturation boost: S shifted left by a small gain plus an offset, clamped to
// full scale instead of wrapping.
module cartoon_sat_boost
  import cartoon_pkg::*;
#(
  parameter int CH_W = DEF_CH_W
) (
  input  logic [CH_W-1:0] s_in,
  input  logic [1:0]      shift,
  input  logic [CH_W-1:0] offset,
  output logic [CH_W-1:0] s_out
);

  logic [CH_W+3:0] s_shl_s;

  // Four guard bits hold the largest shift, so only the clamp can limit the result.
  always_comb begin
    s_shl_s = {4'b0000, s_in} << shift;
    s_out   = CH_W'(sat_add(32'(s_shl_s), 32'(offset), CH_W));
  end

endmodule

// File: rtl/cartoon_fx.sv
// Two-stage cartoon effect on HSV pixels with frame-synchronous config shadowing,
// saturation boost, V posterisation, horizontal edge dilation and four output modes.
module cartoon_fx
  import cartoon_pkg::*;
#(
  parameter int              CH_W       = DEF_CH_W,
  parameter int              DIL_W      = 3,
  parameter logic [CH_W-1:0] DEF_THRESH = CH_W'(8'h40),
  parameter logic [CH_W-1:0] DEF_OFFSET = CH_W'(8'd50)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CH_W-1:0]  edge_thresh,
  input  logic [1:0]       sat_shift,
  input  logic [CH_W-1:0]  sat_offset,
  input  logic [2:0]       post_bits,
  input  logic [DIL_W-1:0] dil_len,
  cartoon_fx_if.slave      bus
);

  localparam int PIX_W = 3 * CH_W;
  localparam int H_LSB = h_lsb(CH_W);
  localparam int S_LSB = s_lsb(CH_W);
  localparam int V_LSB = v_lsb(CH_W);

  logic             vs_prev_q, vs_prev_d, load_s;
  logic             en_q, en_d;
  mode_e            mode_q, mode_d;
  logic [CH_W-1:0]  thresh_q, thresh_d, offset_q, offset_d;
  logic [1:0]       shift_q, shift_d;
  logic [2:0]       post_q, post_d;
  logic [DIL_W-1:0] dil_len_q, dil_len_d, cnt_q, cnt_d;

  logic             edge_raw_s, edge_f_s;
  logic [CH_W-1:0]  h_blur_s, s_blur_s, v_blur_s, s_boost_s, v_mask_s, v_post_s;

  logic             s1_valid_q, s1_valid_d, s1_vsync_q, s1_vsync_d, s1_hsync_q, s1_hsync_d;
  logic             s1_edge_q, s1_edge_d, s1_en_q, s1_en_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [PIX_W-1:0] s1_blur_q, s1_blur_d, s1_pix_q, s1_pix_d, s1_pass_q, s1_pass_d;
  logic [CH_W-1:0]  s1_sat_q, s1_sat_d, s1_post_q, s1_post_d;

  logic             out_valid_q, out_valid_d, out_vsync_q, out_vsync_d, out_hsync_q, out_hsync_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d, out_pass_q, out_pass_d;
  logic [CH_W-1:0]  s1_h_s, s1_s_s, s1_v_s;

  // The *_d shadow values are what the current pixel uses, so a load cycle sees new config.
  always_comb begin
    vs_prev_d = bus.in_vsync;
    load_s    = bus.in_vsync & ~vs_prev_q;
    if (load_s) begin
      en_d      = en;
      mode_d    = mode_e'(mode);
      thresh_d  = edge_thresh;
      shift_d   = sat_shift;
      offset_d  = sat_offset;
      post_d    = post_bits;
      dil_len_d = dil_len;
    end else begin
      en_d      = en_q;
      mode_d    = mode_q;
      thresh_d  = thresh_q;
      shift_d   = shift_q;
      offset_d  = offset_q;
      post_d    = post_q;
      dil_len_d = dil_len_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q <= 1'b0;
      en_q      <= 1'b0;
      mode_q    <= MODE_BYPASS;
      thresh_q  <= DEF_THRESH;
      shift_q   <= 2'd0;
      offset_q  <= DEF_OFFSET;
      post_q    <= 3'd0;
      dil_len_q <= {DIL_W{1'b0}};
    end else begin
      vs_prev_q <= vs_prev_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      thresh_q  <= thresh_d;
      shift_q   <= shift_d;
      offset_q  <= offset_d;
      post_q    <= post_d;
      dil_len_q <= dil_len_d;
    end
  end

  cartoon_sat_boost #(.CH_W(CH_W)) u_sat_boost (
    .s_in   (s_blur_s),
    .shift  (shift_d),
    .offset (offset_d),
    .s_out  (s_boost_s)
  );

  // Stage 1: edge detect with dilation, saturation boost and posterise.
  always_comb begin
    h_blur_s   = bus.blur_in[H_LSB +: CH_W];
    s_blur_s   = bus.blur_in[S_LSB +: CH_W];
    v_blur_s   = bus.blur_in[V_LSB +: CH_W];
    edge_raw_s = bus.edge_in > thresh_d;
    if (bus.in_hsync) begin
      cnt_d    = {DIL_W{1'b0}};
      edge_f_s = edge_raw_s;
    end else if (bus.in_valid && edge_raw_s) begin
      cnt_d    = dil_len_d;
      edge_f_s = 1'b1;
    end else if (bus.in_valid && (cnt_q != {DIL_W{1'b0}})) begin
      cnt_d    = cnt_q - DIL_W'(1);
      edge_f_s = 1'b1;
    end else begin
      cnt_d    = cnt_q;
      edge_f_s = edge_raw_s | (cnt_q != {DIL_W{1'b0}});
    end
    v_mask_s = {CH_W{1'b1}} << (CH_W - int'(post_d));
    if ((post_d != 3'd0) && (int'(post_d) < CH_W)) begin
      v_post_s = v_blur_s & v_mask_s;
    end else begin
      v_post_s = v_blur_s;
    end
    s1_valid_d = bus.in_valid;
    s1_vsync_d = bus.in_vsync;
    s1_hsync_d = bus.in_hsync;
    s1_edge_d  = edge_f_s;
    s1_en_d    = en_d;
    s1_mode_d  = mode_d;
    s1_blur_d  = bus.blur_in;
    s1_pix_d   = bus.pixel_in;
    s1_pass_d  = bus.pass_in;
    s1_sat_d   = s_boost_s;
    s1_post_d  = v_post_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= {DIL_W{1'b0}};
      s1_valid_q <= 1'b0;
      s1_vsync_q <= 1'b0;
      s1_hsync_q <= 1'b0;
      s1_edge_q  <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_mode_q  <= MODE_BYPASS;
      s1_blur_q  <= {PIX_W{1'b0}};
      s1_pix_q   <= {PIX_W{1'b0}};
      s1_pass_q  <= {PIX_W{1'b0}};
      s1_sat_q   <= {CH_W{1'b0}};
      s1_post_q  <= {CH_W{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_vsync_q <= s1_vsync_d;
      s1_hsync_q <= s1_hsync_d;
      s1_edge_q  <= s1_edge_d;
      s1_en_q    <= s1_en_d;
      s1_mode_q  <= s1_mode_d;
      s1_blur_q  <= s1_blur_d;
      s1_pix_q   <= s1_pix_d;
      s1_pass_q  <= s1_pass_d;
      s1_sat_q   <= s1_sat_d;
      s1_post_q  <= s1_post_d;
    end
  end

  // Stage 2: output select using the config captured with this pixel.
  always_comb begin
    s1_h_s      = s1_blur_q[H_LSB +: CH_W];
    s1_s_s      = s1_blur_q[S_LSB +: CH_W];
    s1_v_s      = s1_blur_q[V_LSB +: CH_W];
    out_valid_d = s1_valid_q;
    out_vsync_d = s1_vsync_q;
    out_hsync_d = s1_hsync_q;
    out_pass_d  = s1_pass_q;
    if (!s1_en_q) begin
      out_pix_d = s1_pix_q;
    end else begin
      case (s1_mode_q)
        MODE_BYPASS: out_pix_d = s1_pix_q;
        MODE_BLACK:  out_pix_d = s1_edge_q ? {s1_h_s, s1_s_s, {CH_W{1'b0}}}
                                           : {s1_h_s, s1_sat_q, s1_post_q};
        MODE_DARKEN: out_pix_d = s1_edge_q ? {s1_h_s, s1_s_s, (s1_v_s >> 2)}
                                           : {s1_h_s, s1_sat_q, s1_post_q};
        MODE_EDGE:   out_pix_d = {{(2*CH_W){1'b0}}, {CH_W{s1_edge_q}}};
        default:     out_pix_d = s1_pix_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_vsync_q <= 1'b0;
      out_hsync_q <= 1'b0;
      out_pix_q   <= {PIX_W{1'b0}};
      out_pass_q  <= {PIX_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_vsync_q <= out_vsync_d;
      out_hsync_q <= out_hsync_d;
      out_pix_q   <= out_pix_d;
      out_pass_q  <= out_pass_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vsync = out_vsync_q;
  assign bus.out_hsync = out_hsync_q;
  assign bus.pixel_out = out_pix_q;
  assign bus.pass_out  = out_pass_q;

endmodule
